telem_readout: RTL and testbench

Reads target telemetry back out of the 16-slot target coordinate store and transmits it as byte-serial frames over a valid/ready stream. It sits between the target store's read port and the downlink/serializer. It is the read-side counterpart to the target-select/load path that writes X, Y, Z and time coordinates per target. It supports a single-target read or a full 16-target sweep per request.

---
 rtl/telem_pkg.sv | 28 ++
 rtl/telem_frame_sel.sv | 40 ++++
 rtl/telem_readout.sv | 128 ++++++++++++
 tb/tb_telem_readout.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/telem_pkg.sv
// Shared constants and types for the telemetry readout path.
// Imported by the readout top and its frame byte selector.
package telem_pkg;

    localparam int NUM_TARGETS = 16;
    localparam int COORD_W     = 8;
    localparam int IDX_W       = $clog2(NUM_TARGETS);
    localparam int FRAME_LEN   = 6;
    localparam int CNT_W       = $clog2(FRAME_LEN);

    localparam logic [3:0] HDR_TAG = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
        logic [COORD_W-1:0] t;
    } coord_t;

endpackage

// File: rtl/telem_frame_sel.sv
// Combinational frame byte selector: header, X, Y, Z, T, checksum.
// The checksum is the 8-bit wrapping sum of header and coordinates.
module telem_frame_sel
    import telem_pkg::*;
(
    input  coord_t             rec_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [CNT_W-1:0]   cnt_i,
    output logic [COORD_W-1:0] data_o,
    output logic               last_o,
    output logic [COORD_W-1:0] csum_o
);

    logic [COORD_W-1:0] hdr;

    assign hdr    = {HDR_TAG, idx_i};
    assign csum_o = hdr + rec_i.x + rec_i.y + rec_i.z + rec_i.t;

    // Pick the byte addressed by the frame position counter
    always_comb begin
        data_o = '0;
        last_o = 1'b0;
        case (cnt_i)
            3'd0: data_o = hdr;
            3'd1: data_o = rec_i.x;
            3'd2: data_o = rec_i.y;
            3'd3: data_o = rec_i.z;
            3'd4: data_o = rec_i.t;
            3'd5: begin
                data_o = csum_o;
                last_o = 1'b1;
            end
            default: begin
                data_o = '0;
                last_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/telem_readout.sv
// Reads target records from the coordinate store and streams them
// as 6-byte frames; single-slot or full 16-slot sweep per request.
module telem_readout
    import telem_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_sweep,
    input  logic [IDX_W-1:0]       req_target,
    output logic                   rd_en,
    output logic [IDX_W-1:0]       rd_addr,
    input  logic [4*COORD_W-1:0]   rd_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [COORD_W-1:0]     tx_data,
    output logic                   tx_last,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            frames_sent
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sweep_q, sweep_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    coord_t             buf_q, buf_d;
    logic [15:0]        frames_q, frames_d;

    logic [COORD_W-1:0] sel_data;
    logic               sel_last;
    logic [COORD_W-1:0] csum_unused;

    telem_frame_sel u_sel (
        .rec_i  (buf_q),
        .idx_i  (idx_q),
        .cnt_i  (cnt_q),
        .data_o (sel_data),
        .last_o (sel_last),
        .csum_o (csum_unused)
    );

    assign rd_addr     = idx_q;
    assign frames_sent = frames_q;

    // State and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            sweep_q  <= 1'b0;
            cnt_q    <= '0;
            buf_q    <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sweep_q  <= sweep_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            frames_q <= frames_d;
        end
    end

    // Next-state logic and Moore outputs of the readout sequencer
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sweep_d   = sweep_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        frames_d  = frames_q;
        req_ready = 1'b0;
        rd_en     = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_last   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy      = 1'b0;
                req_ready = !rst;
                if (req_valid && req_ready) begin
                    sweep_d = req_sweep;
                    idx_d   = req_sweep ? '0 : req_target;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en   = 1'b1;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                buf_d   = coord_t'(rd_data);
                cnt_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = sel_data;
                tx_last  = sel_last;
                if (tx_ready) begin
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        frames_d = frames_q + 16'd1;
                        if (sweep_q && idx_q != IDX_W'(NUM_TARGETS - 1)) begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_telem_readout.sv
// Directed bench for telem_readout with a byte scoreboard,
// a registered store model and an optional toggling tx_ready.
module tb_telem_readout;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_sweep = 1'b0;
    logic [3:0]  req_target = 4'h0;
    logic [31:0] rd_data = 32'h0;
    logic        tx_ready = 1'b1;
    logic        req_ready, rd_en, tx_valid, tx_last, busy, done;
    logic [3:0]  rd_addr;
    logic [7:0]  tx_data;
    logic [15:0] frames_sent;

    logic [31:0] mem [16];
    logic [8:0]  sb [$];
    logic [7:0]  rxlog [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_total = 0;
    int last_cnt = 0;
    int done_cnt = 0;
    int last_cyc = 0;
    int hdr_cyc = 0;
    int acc_c = 0;
    int pos = 0;
    int busy_viol = 0;
    int base = 0;
    bit have_last = 1'b0;
    bit gap_en = 1'b0;
    bit bp = 1'b0;
    bit prev_stall = 1'b0;
    bit seen = 1'b0;
    logic [8:0] prev_byte = 9'h0;

    telem_readout dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sweep   (req_sweep),
        .req_target  (req_target),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .busy        (busy),
        .done        (done),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Store read port: data for the addressed slot one cycle later
    always @(posedge clk) rd_data <= mem[rd_addr];

    always @(posedge clk) begin
        #1;
        tx_ready = bp ? ~tx_ready : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int i);
        logic [31:0] r;
        logic [7:0]  h;
        logic [7:0]  cs;
        r  = mem[i];
        h  = {4'hA, 4'(i)};
        cs = h + r[31:24] + r[23:16] + r[15:8] + r[7:0];
        sb.push_back({1'b0, h});
        sb.push_back({1'b0, r[31:24]});
        sb.push_back({1'b0, r[23:16]});
        sb.push_back({1'b0, r[15:8]});
        sb.push_back({1'b0, r[7:0]});
        sb.push_back({1'b1, cs});
    endtask

    task automatic issue(input logic sw, input logic [3:0] tg);
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_sweep  = sw;
        req_target = tg;
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc_c = cyc;
        chk("fetch_rd", 32'({rd_en, busy, rd_addr}),
            32'({1'b1, 1'b1, (sw ? 4'h0 : tg)}));
    endtask

    task automatic wait_done(input int budget);
        bit got_done;
        got_done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(got_done), 32'd1);
        chk("done_after_last", 32'(cyc - last_cyc), 32'd1);
        @(posedge clk); #1;
        chk("ready_after_done", 32'({req_ready, busy, done}), 32'h4);
    endtask

    task automatic check_frame(input logic [47:0] exp);
        chk("rx_len", 32'(rxlog.size()), 32'd6);
        if (rxlog.size() == 6) begin
            chk("rx_hdr", 32'(rxlog[0]), 32'(exp[47:40]));
            chk("rx_body", {rxlog[1], rxlog[2], rxlog[3], rxlog[4]},
                exp[39:8]);
            chk("rx_csum", 32'(rxlog[5]), 32'(exp[7:0]));
        end
    endtask

    // Stream monitor: scoreboard, stall stability, frame gaps
    always @(negedge clk) begin
        if (rst) begin
            pos = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 32'({tx_valid, tx_last, tx_data}),
                    32'({1'b1, prev_byte}));
            if (done) done_cnt++;
            if (tx_valid && tx_ready) begin
                acc_total++;
                rxlog.push_back(tx_data);
                if (pos == 0) begin
                    if (gap_en && have_last)
                        chk("frame_gap", 32'(cyc - last_cyc), 32'd3);
                    hdr_cyc = cyc;
                end
                if (sb.size() == 0)
                    chk("sb_nonempty", 32'(sb.size()), 32'd1);
                else
                    chk("byte", 32'({tx_last, tx_data}),
                        32'(sb.pop_front()));
                if (tx_last) begin
                    last_cnt++;
                    last_cyc = cyc;
                    have_last = 1'b1;
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = {tx_last, tx_data};
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", 32'({req_ready, rd_en, tx_valid, tx_last, busy, done}),
            32'h0);
        chk("reset_dat", 32'({tx_data, rd_addr, frames_sent}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'({req_ready, busy}), 32'h2);

        // single read of slot 3; store rewritten after capture
        mem[3] = 32'h12345678;
        rxlog.delete();
        push_frame(3);
        issue(1'b0, 4'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem[3] = 32'hDEADBEEF;
        wait_done(40);
        check_frame(48'hA3_12345678_B7);
        chk("hdr_latency", 32'(hdr_cyc - acc_c), 32'd2);
        chk("frame_span", 32'(last_cyc - hdr_cyc), 32'd5);
        chk("frames_1", 32'(frames_sent), 32'd1);
        mem[3] = 32'h12345678;

        // checksum overflow on slot 15
        mem[15] = 32'hFFFFFFFF;
        rxlog.delete();
        push_frame(15);
        issue(1'b0, 4'd15);
        wait_done(40);
        check_frame(48'hAF_FFFFFFFF_AB);
        chk("frames_2", 32'(frames_sent), 32'd2);

        // backpressure: tx_ready toggling every cycle
        rxlog.delete();
        push_frame(3);
        bp = 1'b1;
        issue(1'b0, 4'd3);
        wait_done(80);
        bp = 1'b0;
        check_frame(48'hA3_12345678_B7);
        chk("frames_3", 32'(frames_sent), 32'd3);

        // full sweep
        for (int i = 0; i < 16; i++)
            mem[i] = {8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)};
        for (int i = 0; i < 16; i++) push_frame(i);
        rxlog.delete();
        last_cnt = 0;
        done_cnt = 0;
        have_last = 1'b0;
        gap_en = 1'b1;
        issue(1'b1, 4'd9);
        wait_done(300);
        gap_en = 1'b0;
        chk("sweep_len", 32'(rxlog.size()), 32'd96);
        if (rxlog.size() == 96) begin
            for (int f = 0; f < 16; f++)
                chk("sweep_hdr", 32'(rxlog[f * 6]), 32'({4'hA, 4'(f)}));
            chk("sweep_cs0", 32'(rxlog[5]), 32'h00);
            chk("sweep_cs15", 32'(rxlog[95]), 32'h4B);
        end
        chk("sweep_lasts", 32'(last_cnt), 32'd16);
        chk("sweep_dones", 32'(done_cnt), 32'd1);
        chk("frames_19", 32'(frames_sent), 32'd19);

        // request held across a busy sweep
        for (int i = 0; i < 16; i++) push_frame(i);
        push_frame(5);
        rxlog.delete();
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_sweep = 1'b1;
        req_target = 4'd0;
        @(posedge clk); #1;
        req_sweep = 1'b0;
        req_target = 4'd5;
        chk("coll_fetch", 32'({rd_en, rd_addr}), 32'h10);
        busy_viol = 0;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (req_ready) busy_viol++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("held_not_ready", 32'(busy_viol), 32'd0);
        chk("coll_done", 32'(seen), 32'd1);
        @(posedge clk); #1;
        chk("held_ready", 32'({req_ready, busy}), 32'h2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("held_fetch", 32'({rd_en, rd_addr}), 32'h15);
        wait_done(40);
        chk("coll_len", 32'(rxlog.size()), 32'd102);
        if (rxlog.size() == 102) begin
            chk("coll_hdr5", 32'(rxlog[96]), 32'hA5);
            chk("coll_cs5", 32'(rxlog[101]), 32'h19);
        end
        chk("frames_36", 32'(frames_sent), 32'd36);

        // reset after two accepted bytes
        mem[7] = 32'hC0FFEE11;
        push_frame(7);
        rxlog.delete();
        base = acc_total;
        issue(1'b0, 4'd7);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (acc_total - base >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("two_bytes", 32'(seen), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid", 32'({tx_valid, busy, req_ready}), 32'h1);
        chk("rst_frames", 32'(frames_sent), 32'd0);
        sb.delete();
        rxlog.delete();
        push_frame(7);
        issue(1'b0, 4'd7);
        wait_done(40);
        check_frame(48'hA7_C0FFEE11_65);
        chk("frames_after_rst", 32'(frames_sent), 32'd1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
